cache_fill_arbiter: RTL and testbench
=====================================

# cache_fill_arbiter

- Shares one SDRAM burst-read port between two two-way cache instances (requester 0 = 68k cache, requester 1 = Z80/aux cache).
- Each cache raises a level fill request with its miss address. The arbiter grants one requester and issues a critical-word-first burst request to the SDRAM controller.
- It forwards the returned 8-word burst, aligned with a per-requester fill strobe, to the granted cache only.
- It sits between the caches' `sdram_req`/`sdram_fill`/`data_from_sdram` pins and the SDRAM controller's cache port.

## Interface
Parameters:
- `ADDR_W`, 26: byte-address width; 64 MB space.
- `DATA_W`, 16: word width.
- `BURST_LEN`, 8: words per cacheline fill; power of two.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: reset; asynchronous, active-low.
- `req0` / `req1` in 1: fill request from cache 0/1. Level; held until that cache sees its first fill strobe.
- `addr0` / `addr1` in `ADDR_W`: miss byte address from cache 0/1. Stable while the matching `req` is high.
- `fill0` / `fill1` out 1: per-word fill strobe to cache 0/1.
- `fill_data` out `DATA_W`: burst word, shared by both caches, valid with `fillN`.
- `sdram_req` out 1: burst request to the SDRAM controller.
- `sdram_addr` out `ADDR_W-1`: word address `[ADDR_W-1:1]`. Bits `[3:1]` carry the critical word.
- `sdram_ack` in 1: one-cycle pulse; controller accepted the request.
- `sdram_fill` in 1: high for `BURST_LEN` consecutive cycles with `sdram_data`.
- `sdram_data` in `DATA_W`: burst data.
- `owner` out 1: current/last grantee.
- `busy` out 1: high in any state other than IDLE.
- `proto_err` out 1: sticky protocol-error flag; cleared only by reset.

## Operation
States:
- **IDLE**: if either `req` is high, pick a grantee, latch its address into `sdram_addr`, set `owner`, then go to ISSUE.
- **ISSUE**: `sdram_req`=1. On `sdram_ack`, `sdram_req`←0 and go to WAITDATA. The address is frozen throughout.
- **WAITDATA**: on the first `sdram_fill`, go to BURST. The burst counter counts this word as 1.
- **BURST**: count `sdram_fill` cycles. After word `BURST_LEN`, go to RELEASE.
  - If `sdram_fill` drops mid-burst: set `proto_err`, abandon the burst, go to RELEASE.
- **RELEASE**: one dead cycle; no grant is made. Go to IDLE.

Arbitration and forwarding rules:
- A request arriving during a burst waits. It is evaluated in IDLE after RELEASE.
- Fill forwarding: `fillN` = `sdram_fill` registered, gated by `owner==N` and state ∈ {WAITDATA, BURST}. `fill_data` is `sdram_data` registered in the same cycle.
- An `sdram_fill` in IDLE or ISSUE is dropped and sets `proto_err`.
- An `sdram_ack` outside ISSUE is ignored and sets `proto_err`.
- A requester's `req` dropping before its grant is legal; the grant decision uses the IDLE-cycle sample only.
- The burst counter is `log2(BURST_LEN)+1` bits and is cleared on entry to WAITDATA.
- Reset, including mid-burst, goes to IDLE. Reset values:
  - `sdram_req`=0, `fill0`=`fill1`=0
  - `fill_data`=0, `sdram_addr`=0
  - `owner`=1, so requester 0 wins first under round-robin
  - `busy`=0, `proto_err`=0

## Timing
- Request to `sdram_req`: 1 cycle (IDLE sample → ISSUE).
- `sdram_fill`/`sdram_data` → `fillN`/`fill_data`: exactly 1 cycle. Word order and spacing are preserved.
- Minimum turnaround between back-to-back grants: last fill word → RELEASE → IDLE → ISSUE, i.e. 3 cycles from the last `sdram_fill` to the next `sdram_req`.
- `fillN` is never high for a non-owner. At most one `fillN` is high in any cycle.

## Configuration
- `CACHE_ARB_ROUND_ROBIN_EN` defined: when both requests are high in IDLE, the requester that is not `owner` wins. A lone requester always wins.
- Undefined: fixed priority; requester 0 wins any simultaneous request.

## Structure
- Shared package `fpgagen_cache_pkg` holds:
  - the state enum (`ARB_IDLE`, `ARB_ISSUE`, `ARB_WAITDATA`, `ARB_BURST`, `ARB_RELEASE`)
  - the `CACHE_BURST_LEN`=8 and `CACHE_ADDR_W`=26 constants, also used by the cache
- One sub-module, `cache_arb_pick`: the 2-way grant decision from (`req0`, `req1`, `owner`), including the macro-selected policy. It is purely combinational.

## Test plan
- **Single fill**: `req0`=1, `addr0`=0x012346.
  - `sdram_req` rises next cycle with `sdram_addr`=0x0091A3.
  - After ack and 8 fills of 0xA000..0xA007, `fill0` is high for 8 cycles, 1 cycle later, carrying the same data. `fill1` stays 0.
- **Simultaneous requests, macro defined**: `req0`=`req1`=1 from reset → grant 0, then grant 1. Repeat the pair → grant 0 again.
  - Macro undefined, with `req0` re-raised during burst 1 → requester 0 always wins.
- **Request during burst**: `req1` rises at burst word 3 of a grant to 0 → `sdram_req` for 1 rises 3 cycles after the last fill word.
- **Short burst**: `sdram_fill` drops after word 5 → `proto_err`=1, returns to IDLE, and the next request is served normally.
- **Stray fill**: `sdram_fill` pulses in IDLE → no `fillN`, `proto_err`=1.
- **Reset mid-burst**: `reset_n`=0 at word 4 → `fill0`, `sdram_req` and `busy` are 0 immediately (asynchronous). After release, a new `req1` is granted normally.

Source files
------------

// File: rtl/cache_fill_arbiter_pkg.sv
// Shared cache-fill definitions: arbiter state encoding and the line geometry
// constants also used by the two-way caches.
package fpgagen_cache_pkg;

   localparam int unsigned CACHE_ADDR_W    = 26;
   localparam int unsigned CACHE_DATA_W    = 16;
   localparam int unsigned CACHE_BURST_LEN = 8;

   typedef enum logic [2:0] {
      ARB_IDLE     = 3'd0,
      ARB_ISSUE    = 3'd1,
      ARB_WAITDATA = 3'd2,
      ARB_BURST    = 3'd3,
      ARB_RELEASE  = 3'd4
   } arb_state_t;

   // States in which returned SDRAM words belong to the current grantee
   function automatic logic arb_fill_window(input arb_state_t s);
      return (s == ARB_WAITDATA) || (s == ARB_BURST);
   endfunction

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// Cache-side and SDRAM-side fill signals of the arbiter, bundled.
// master = arbiter view, slave = caches/controller view.
interface cache_fill_arbiter_if
   import fpgagen_cache_pkg::*;
#(
   parameter int unsigned ADDR_W = CACHE_ADDR_W,
   parameter int unsigned DATA_W = CACHE_DATA_W
);
   logic              req0;
   logic              req1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic              fill0;
   logic              fill1;
   logic [DATA_W-1:0] fill_data;
   logic              sdram_req;
   logic [ADDR_W-2:0] sdram_addr;
   logic              sdram_ack;
   logic              sdram_fill;
   logic [DATA_W-1:0] sdram_data;
   logic              owner;
   logic              busy;
   logic              proto_err;

   modport master (
      input  req0, req1, addr0, addr1, sdram_ack, sdram_fill, sdram_data,
      output fill0, fill1, fill_data, sdram_req, sdram_addr, owner, busy, proto_err
   );

   modport slave (
      output req0, req1, addr0, addr1, sdram_ack, sdram_fill, sdram_data,
      input  fill0, fill1, fill_data, sdram_req, sdram_addr, owner, busy, proto_err
   );

endinterface

// File: rtl/cache_fill_arbiter_pick.sv
// Two-way combinational grant decision. CACHE_ARB_ROUND_ROBIN_EN selects
// round-robin on a tie; otherwise requester 0 has fixed priority.
module cache_arb_pick
   import fpgagen_cache_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic owner,
   output logic grant_valid_c,
   output logic grant_c
);

`ifdef CACHE_ARB_ROUND_ROBIN_EN
   // On a tie the requester that did not own the port last time wins
   always_comb begin
      grant_valid_c = req0 | req1;
      grant_c       = 1'b0;
      if (req0 && req1)
         grant_c = ~owner;
      else
         grant_c = req1;
   end
`else
   logic unused_owner;
   assign unused_owner = owner;

   always_comb begin
      grant_valid_c = req0 | req1;
      grant_c       = 1'b0;
      if (!req0 && req1)
         grant_c = 1'b1;
   end
`endif

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares one SDRAM burst-read port between two caches: grants one requester,
// issues its critical-word-first burst and steers the returned words to it.
// Tie policy selected by CACHE_ARB_ROUND_ROBIN_EN (see cache_arb_pick).
module cache_fill_arbiter
   import fpgagen_cache_pkg::*;
#(
   parameter int unsigned ADDR_W    = CACHE_ADDR_W,
   parameter int unsigned DATA_W    = CACHE_DATA_W,
   parameter int unsigned BURST_LEN = CACHE_BURST_LEN
)(
   input  logic                 clk,
   input  logic                 reset_n,
   cache_fill_arbiter_if.master bus
);

   localparam int unsigned CNT_W = $clog2(BURST_LEN) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

   arb_state_t        state;
   logic [CNT_W-1:0]  burst_cnt;
   logic              owner_q;
   logic              sdram_req_q;
   logic [ADDR_W-2:0] sdram_addr_q;
   logic              fill0_q;
   logic              fill1_q;
   logic [DATA_W-1:0] fill_data_q;
   logic              busy_q;
   logic              proto_err_q;

   logic grant_valid_c;
   logic grant_c;
   logic fwd_c;

   cache_arb_pick u_pick (
      .req0          (bus.req0),
      .req1          (bus.req1),
      .owner         (owner_q),
      .grant_valid_c (grant_valid_c),
      .grant_c       (grant_c)
   );

   assign fwd_c = bus.sdram_fill && arb_fill_window(state);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ARB_IDLE;
         burst_cnt    <= '0;
         owner_q      <= 1'b1;
         sdram_req_q  <= 1'b0;
         sdram_addr_q <= '0;
         fill0_q      <= 1'b0;
         fill1_q      <= 1'b0;
         fill_data_q  <= '0;
         busy_q       <= 1'b0;
         proto_err_q  <= 1'b0;
      end else begin
         // Returned words go one cycle later to the grantee only
         fill0_q <= fwd_c && !owner_q;
         fill1_q <= fwd_c &&  owner_q;
         if (fwd_c)
            fill_data_q <= bus.sdram_data;

         if (bus.sdram_ack && (state != ARB_ISSUE))
            proto_err_q <= 1'b1;

         case (state)
            ARB_IDLE: begin
               if (bus.sdram_fill)
                  proto_err_q <= 1'b1;
               if (grant_valid_c) begin
                  owner_q      <= grant_c;
                  sdram_addr_q <= grant_c ? bus.addr1[ADDR_W-1:1]
                                          : bus.addr0[ADDR_W-1:1];
                  sdram_req_q  <= 1'b1;
                  busy_q       <= 1'b1;
                  state        <= ARB_ISSUE;
               end
            end

            ARB_ISSUE: begin
               if (bus.sdram_fill)
                  proto_err_q <= 1'b1;
               if (bus.sdram_ack) begin
                  sdram_req_q <= 1'b0;
                  burst_cnt   <= '0;
                  state       <= ARB_WAITDATA;
               end
            end

            ARB_WAITDATA: begin
               if (bus.sdram_fill) begin
                  burst_cnt <= CNT_W'(1);
                  state     <= (BURST_LEN == 1) ? ARB_RELEASE : ARB_BURST;
               end
            end

            // A gap inside the burst is a controller fault: give up the line
            ARB_BURST: begin
               if (bus.sdram_fill) begin
                  burst_cnt <= burst_cnt + CNT_W'(1);
                  if (burst_cnt == LAST_CNT)
                     state <= ARB_RELEASE;
               end else begin
                  proto_err_q <= 1'b1;
                  state       <= ARB_RELEASE;
               end
            end

            ARB_RELEASE: begin
               busy_q <= 1'b0;
               state  <= ARB_IDLE;
            end

            default: begin
               sdram_req_q <= 1'b0;
               busy_q      <= 1'b0;
               state       <= ARB_IDLE;
            end
         endcase
      end
   end

   assign bus.owner      = owner_q;
   assign bus.sdram_req  = sdram_req_q;
   assign bus.sdram_addr = sdram_addr_q;
   assign bus.fill0      = fill0_q;
   assign bus.fill1      = fill1_q;
   assign bus.fill_data  = fill_data_q;
   assign bus.busy       = busy_q;
   assign bus.proto_err  = proto_err_q;

   // Byte-lane bit of the miss address is not part of the word address
   logic unused_addr_lsb;
   assign unused_addr_lsb = bus.addr0[0] ^ bus.addr1[0];

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter: grant, forwarding, turnaround,
// protocol errors and reset behaviour.
module tb_cache_fill_arbiter;
   import fpgagen_cache_pkg::*;

   localparam int unsigned AW = 26;
   localparam int unsigned DW = 16;
   localparam int unsigned BL = 8;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   total   = 0;
   int   bad     = 0;

   cache_fill_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   cache_fill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req0       = 1'b0;
      bus.req1       = 1'b0;
      bus.addr0      = '0;
      bus.addr1      = '0;
      bus.sdram_ack  = 1'b0;
      bus.sdram_fill = 1'b0;
      bus.sdram_data = '0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      clear_inputs();
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   // One complete grant: IDLE sample, ack, a spare wait cycle, n words, release.
   // The grantee drops its req after its first strobe; raise_at injects a req.
   task automatic serve(input logic exp_owner, input logic [AW-1:0] addr, input int n,
                        input logic [DW-1:0] base, input int raise_at,
                        input logic raise_who, input logic exp_perr);
      tick();
      check("sdram_req_rise", 32'(bus.sdram_req), 32'd1);
      check("owner", 32'(bus.owner), 32'(exp_owner));
      check("sdram_addr", 32'(bus.sdram_addr), 32'(addr >> 1));
      check("busy_grant", 32'(bus.busy), 32'd1);
      bus.sdram_ack = 1'b1;
      tick();
      bus.sdram_ack = 1'b0;
      check("sdram_req_fall", 32'(bus.sdram_req), 32'd0);
      tick();
      for (int i = 0; i < n; i++) begin
         if (i == raise_at) begin
            if (raise_who) bus.req1 = 1'b1;
            else           bus.req0 = 1'b1;
         end
         bus.sdram_fill = 1'b1;
         bus.sdram_data = base + DW'(i);
         tick();
         check("fill0", 32'(bus.fill0), 32'(!exp_owner));
         check("fill1", 32'(bus.fill1), 32'(exp_owner));
         check("fill_data", 32'(bus.fill_data), 32'(base + DW'(i)));
         if (i == 0) begin
            if (exp_owner) bus.req1 = 1'b0;
            else           bus.req0 = 1'b0;
         end
      end
      bus.sdram_fill = 1'b0;
      bus.sdram_data = '0;
      if (n < int'(BL)) begin
         tick();
         check("fill_off_short", 32'({bus.fill1, bus.fill0}), 32'd0);
      end
      tick();
      check("fill_off", 32'({bus.fill1, bus.fill0}), 32'd0);
      check("release_no_req", 32'(bus.sdram_req), 32'd0);
      check("busy_release", 32'(bus.busy), 32'd0);
      check("proto_err", 32'(bus.proto_err), 32'(exp_perr));
   endtask

   initial begin
      clear_inputs();
      reset_n = 1'b0;
      tick();
      tick();
      check("rst_sdram_req", 32'(bus.sdram_req), 32'd0);
      check("rst_fill0", 32'(bus.fill0), 32'd0);
      check("rst_fill1", 32'(bus.fill1), 32'd0);
      check("rst_fill_data", 32'(bus.fill_data), 32'd0);
      check("rst_sdram_addr", 32'(bus.sdram_addr), 32'd0);
      check("rst_owner", 32'(bus.owner), 32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_proto_err", 32'(bus.proto_err), 32'd0);
      reset_n = 1'b1;
      tick();
      check("idle_busy", 32'(bus.busy), 32'd0);

      // Single fill for requester 0
      bus.req0  = 1'b1;
      bus.addr0 = 26'h0012346;
      serve(1'b0, 26'h0012346, 8, 16'hA000, -1, 1'b0, 1'b0);

      // Simultaneous requests straight out of reset
      do_reset();
      bus.req0  = 1'b1;
      bus.req1  = 1'b1;
      bus.addr0 = 26'h0000001;
      bus.addr1 = 26'h3FFFFFE;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      serve(1'b0, 26'h0000001, 8, 16'hB000, -1, 1'b0, 1'b0);
      serve(1'b1, 26'h3FFFFFE, 8, 16'hB100, -1, 1'b0, 1'b0);
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      serve(1'b0, 26'h0000001, 8, 16'hB200, -1, 1'b0, 1'b0);
      serve(1'b1, 26'h3FFFFFE, 8, 16'hB300, -1, 1'b0, 1'b0);
`else
      serve(1'b0, 26'h0000001, 8, 16'hB000, 2, 1'b0, 1'b0);
      serve(1'b0, 26'h0000001, 8, 16'hB100, -1, 1'b0, 1'b0);
      serve(1'b1, 26'h3FFFFFE, 8, 16'hB200, -1, 1'b0, 1'b0);
`endif

      // Request arriving mid-burst waits for release, then issues 3 cycles later
      bus.req0  = 1'b1;
      bus.addr0 = 26'h0000040;
      bus.addr1 = 26'h155554;
      serve(1'b0, 26'h0000040, 8, 16'h1230, 2, 1'b1, 1'b0);
      serve(1'b1, 26'h155554, 8, 16'h4560, -1, 1'b0, 1'b0);

      // Short burst: five words then the strobe drops
      bus.req0  = 1'b1;
      bus.addr0 = 26'h0001000;
      serve(1'b0, 26'h0001000, 5, 16'hC000, -1, 1'b0, 1'b1);
      bus.req1  = 1'b1;
      bus.addr1 = 26'h0002002;
      serve(1'b1, 26'h0002002, 8, 16'hC100, -1, 1'b0, 1'b1);

      // Stray fill in IDLE
      do_reset();
      check("perr_cleared", 32'(bus.proto_err), 32'd0);
      bus.sdram_fill = 1'b1;
      bus.sdram_data = 16'hBEEF;
      tick();
      bus.sdram_fill = 1'b0;
      bus.sdram_data = '0;
      check("stray_fill_strobes", 32'({bus.fill1, bus.fill0}), 32'd0);
      check("stray_fill_perr", 32'(bus.proto_err), 32'd1);
      check("stray_fill_busy", 32'(bus.busy), 32'd0);

      // Stray ack in IDLE
      do_reset();
      bus.sdram_ack = 1'b1;
      tick();
      bus.sdram_ack = 1'b0;
      check("stray_ack_perr", 32'(bus.proto_err), 32'd1);
      check("stray_ack_req", 32'(bus.sdram_req), 32'd0);
      check("stray_ack_busy", 32'(bus.busy), 32'd0);

      // Reset asserted at burst word 4
      do_reset();
      bus.req0  = 1'b1;
      bus.addr0 = 26'h0000100;
      tick();
      check("mid_req", 32'(bus.sdram_req), 32'd1);
      bus.sdram_ack = 1'b1;
      tick();
      bus.sdram_ack = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         bus.sdram_fill = 1'b1;
         bus.sdram_data = 16'hD000 + 16'(i);
         tick();
         if (i == 0) bus.req0 = 1'b0;
      end
      check("mid_fill0_before", 32'(bus.fill0), 32'd1);
      reset_n = 1'b0;
      #1;
      check("mid_async_fill0", 32'(bus.fill0), 32'd0);
      check("mid_async_req", 32'(bus.sdram_req), 32'd0);
      check("mid_async_busy", 32'(bus.busy), 32'd0);
      check("mid_async_owner", 32'(bus.owner), 32'd1);
      bus.sdram_fill = 1'b0;
      bus.sdram_data = '0;
      tick();
      reset_n = 1'b1;
      tick();
      bus.req1  = 1'b1;
      bus.addr1 = 26'h0000202;
      serve(1'b1, 26'h0000202, 8, 16'hE000, -1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
